// File: rtl/pipe_pkg.sv
// Shared definitions for the skid-buffered pipeline stage: occupancy encoding,
// the all-zero NOP payload and the default payload width.
package pipe_pkg;

    // pc 32 + instr 32 + O 32 + B 32 + E 3
    localparam int PIPE_DATA_W = 131;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_MAIN  = 2'd1,
        ST_FULL  = 2'd2
    } occ_e;

    // Payload presented downstream for bubbles and flushed slots
    localparam logic [PIPE_DATA_W-1:0] PIPE_NOP = '0;

endpackage

// File: rtl/pipe_data_reg.sv
// Payload holding register with load enable and synchronous clear.
// Clear wins over load so a vacated or flushed slot always reads as NOP.
module pipe_data_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W
) (
    input  logic              clock,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // Clear has priority over load
    always_ff @(posedge clock) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, 2-entry skid buffer
// and synchronous flush-to-bubble. in_ready is registered and never depends on
// out_ready combinationally. Empty or flushed slots present an all-zero payload.
// Optional statistics counters are built when PIPE_STAGE_STATS_EN is defined.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0]  stat_bubbles,
    output logic [CNT_W-1:0]  stat_flushes
`endif
);

    if (DATA_W < 1) begin : g_bad_data_w
        $error("pipe_stage_skid: DATA_W must be at least 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pipe_stage_skid: CNT_W must be at least 1");
    end

    occ_e              state_q;
    occ_e              state_d;
    logic              in_ready_q;
    logic              accept;
    logic              emit;
    logic              main_en;
    logic              main_vacate;
    logic              skid_en;
    logic              skid_vacate;
    logic              main_clr;
    logic              skid_clr;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;

    assign accept = in_valid & in_ready_q;
    assign emit   = out_valid & out_ready;

    // Occupancy next-state and register load/vacate decisions
    always_comb begin
        state_d     = state_q;
        main_en     = 1'b0;
        main_vacate = 1'b0;
        skid_en     = 1'b0;
        skid_vacate = 1'b0;
        main_d      = in_data;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_MAIN;
                    main_en = 1'b1;
                end
            end
            ST_MAIN: begin
                if (accept && emit) begin
                    main_en = 1'b1;
                end else if (accept) begin
                    state_d = ST_FULL;
                    skid_en = 1'b1;
                end else if (emit) begin
                    state_d     = ST_EMPTY;
                    main_vacate = 1'b1;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only the skid entry can advance
                if (emit) begin
                    state_d     = ST_MAIN;
                    main_en     = 1'b1;
                    main_d      = skid_q;
                    skid_vacate = 1'b1;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        // Flush and reset drop everything, including any accept/emit this cycle
        if (!reset || flush) begin
            state_d = ST_EMPTY;
        end
    end

    assign main_clr = !reset || flush || main_vacate;
    assign skid_clr = !reset || flush || skid_vacate;

    // Occupancy state and registered ready
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_FULL);
        end
    end

    pipe_data_reg #(
        .DATA_W (DATA_W)
    ) u_main (
        .clock (clock),
        .clr   (main_clr),
        .en    (main_en),
        .d     (main_d),
        .q     (main_q)
    );

    pipe_data_reg #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clock (clock),
        .clr   (skid_clr),
        .en    (skid_en),
        .d     (in_data),
        .q     (skid_q)
    );

`ifdef PIPE_STAGE_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [CNT_W-1:0] bubbles_q;
    logic [CNT_W-1:0] flushes_q;

    assign stat_bubbles = bubbles_q;
    assign stat_flushes = flushes_q;

    // Saturating counts of idle output cycles and flushes that discarded data
    always_ff @(posedge clock) begin
        if (!reset) begin
            bubbles_q <= '0;
            flushes_q <= '0;
        end else begin
            if (!out_valid) begin
                bubbles_q <= sat_inc(bubbles_q);
            end
            if (flush && out_valid) begin
                flushes_q <= sat_inc(flushes_q);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid: directed scenarios followed by random traffic,
// all checked every cycle against a queue-based model of a 2-deep FIFO stage.
module tb_pipe_stage_skid;

    localparam int DATA_W  = 131;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clock = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_W-1:0]  stat_bubbles;
    logic [CNT_W-1:0]  stat_flushes;
`endif

    pipe_stage_skid #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stat_bubbles (stat_bubbles),
        .stat_flushes (stat_flushes)
`endif
    );

    always #5 clock = ~clock;

    int compared   = 0;
    int mismatched = 0;

    // Reference: entries held by the stage, oldest first
    logic [DATA_W-1:0] mq[$];
    int                m_bub = 0;
    int                m_flu = 0;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [DATA_W-1:0] head;
        head = (mq.size() > 0) ? mq[0] : '0;
        chk("m_out_valid", DATA_W'(out_valid), DATA_W'(mq.size() > 0));
        chk("m_out_data", out_data, head);
        chk("m_in_ready", DATA_W'(in_ready), DATA_W'(mq.size() < 2));
`ifdef PIPE_STAGE_STATS_EN
        chk("m_stat_bubbles", DATA_W'(stat_bubbles), DATA_W'(m_bub));
        chk("m_stat_flushes", DATA_W'(stat_flushes), DATA_W'(m_flu));
`endif
    endtask

    // Drive one cycle of inputs, advance model and DUT, then check 1 time unit after the edge
    task automatic cycle(input logic rst_n, input logic fl, input logic iv,
                         input logic [DATA_W-1:0] d, input logic ordy);
        int sz;
        bit acc;
        bit emt;
        reset     = rst_n;
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        sz  = mq.size();
        acc = iv && (sz < 2);
        emt = (sz > 0) && ordy;
        @(posedge clock);
        if (!rst_n) begin
            mq.delete();
            m_bub = 0;
            m_flu = 0;
        end else begin
            if (sz == 0 && m_bub < CNT_MAX) m_bub++;
            if (fl && sz > 0 && m_flu < CNT_MAX) m_flu++;
            if (fl) begin
                mq.delete();
            end else begin
                if (emt) void'(mq.pop_front());
                if (acc) mq.push_back(d);
            end
        end
        #1;
        check_model();
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r = {r[DATA_W-33:0], 32'($urandom)};
        end
        return r;
    endfunction

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset held low for two cycles
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("rst_out_valid", DATA_W'(out_valid), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_in_ready", DATA_W'(in_ready), DATA_W'(1));
`ifdef PIPE_STAGE_STATS_EN
        chk("rst_stat_bubbles", DATA_W'(stat_bubbles), '0);
        chk("rst_stat_flushes", DATA_W'(stat_flushes), '0);
`endif

        // Back-to-back stream with downstream always ready
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b1, 1'b0, 1'b1, DATA_W'(k), 1'b1);
            chk("stream_data", out_data, DATA_W'(k));
            chk("stream_in_ready", DATA_W'(in_ready), DATA_W'(1));
        end
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
        chk("stream_drained", DATA_W'(out_valid), '0);

        // Stall into FULL, then release
        cycle(1'b1, 1'b0, 1'b1, DATA_W'('hA), 1'b0);
        chk("stall_first", out_data, DATA_W'('hA));
        cycle(1'b1, 1'b0, 1'b1, DATA_W'('hB), 1'b0);
        chk("stall_full_ready", DATA_W'(in_ready), '0);
        chk("stall_full_data", out_data, DATA_W'('hA));
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
        chk("stall_second", out_data, DATA_W'('hB));
        chk("stall_ready_back", DATA_W'(in_ready), DATA_W'(1));
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
        chk("stall_empty_data", out_data, '0);

        // Flush while FULL with a pending input
        cycle(1'b1, 1'b0, 1'b1, DATA_W'(1), 1'b0);
        cycle(1'b1, 1'b0, 1'b1, DATA_W'(2), 1'b0);
        cycle(1'b1, 1'b1, 1'b1, DATA_W'('hC), 1'b0);
        chk("flush_valid", DATA_W'(out_valid), '0);
        chk("flush_data", out_data, '0);
        chk("flush_ready", DATA_W'(in_ready), DATA_W'(1));
        // Flush from MAIN discards both the accept and the emit
        cycle(1'b1, 1'b0, 1'b1, DATA_W'(3), 1'b0);
        cycle(1'b1, 1'b1, 1'b1, DATA_W'('hD), 1'b1);
        chk("flush_main_valid", DATA_W'(out_valid), '0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
            chk("flush_no_emit", DATA_W'(out_valid), '0);
        end
`ifdef PIPE_STAGE_STATS_EN
        chk("flush_count", DATA_W'(stat_flushes), DATA_W'(2));
`endif

        // Reset dominates flush in FULL
        cycle(1'b1, 1'b0, 1'b1, DATA_W'(4), 1'b0);
        cycle(1'b1, 1'b0, 1'b1, DATA_W'(5), 1'b0);
        cycle(1'b0, 1'b1, 1'b1, DATA_W'('hE), 1'b1);
        chk("rvf_valid", DATA_W'(out_valid), '0);
        chk("rvf_data", out_data, '0);
        chk("rvf_ready", DATA_W'(in_ready), DATA_W'(1));
`ifdef PIPE_STAGE_STATS_EN
        chk("rvf_stat_flushes", DATA_W'(stat_flushes), '0);
`endif

        // Idle long enough to saturate the bubble counter
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
        end
`ifdef PIPE_STAGE_STATS_EN
        chk("stat_bubbles_sat", DATA_W'(stat_bubbles), DATA_W'(CNT_MAX));
`endif

        // Random traffic with occasional flush and reset
        for (int k = 0; k < 600; k++) begin
            logic rn;
            logic fl;
            logic iv;
            logic ordy;
            rn   = ($urandom_range(0, 63) != 0);
            fl   = ($urandom_range(0, 15) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = (k < 300) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 2) == 0);
            cycle(rn, fl, iv, rnd_data(), ordy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
